// File: rtl/uart_flit_rx.sv
// rtl/uart_flit_rx.sv - UART byte receiver packing bytes LSB-first into flits on a valid/ready port
// Optional 8E1 framing with parity_err output when UART_FLIT_RX_PARITY_EN is defined.
module uart_flit_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FLIT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  uart_rx,
  output logic [FLIT_WIDTH-1:0] flit_data,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  frame_err,
  output logic                  overrun
`ifdef UART_FLIT_RX_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int NBYTES = FLIT_WIDTH / 8;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  logic                  rx_m;
  logic                  rx_s;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic [IW-1:0]         idx;
  logic [FLIT_WIDTH-1:0] asm_q;
  logic                  flit_done;
  logic                  par_ok;

`ifdef UART_FLIT_RX_PARITY_EN
  logic par_bad;
  assign par_ok = !par_bad;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      idx        <= '0;
      asm_q      <= '0;
      flit_done  <= 1'b0;
      flit_data  <= '0;
      flit_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_FLIT_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      flit_done <= 1'b0;
`ifdef UART_FLIT_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_FLIT_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_FLIT_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            par_bad <= ^{shreg, rx_s};
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s && par_ok) begin
              asm_q[{idx, 3'b000} +: 8] <= shreg;
              if (idx == IDX_LAST) begin
                idx       <= '0;
                flit_done <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
              state <= IDLE;
            end else begin
              // Bad byte abandons the partial flit; BREAK holds off until the line idles.
              frame_err <= 1'b1;
`ifdef UART_FLIT_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              idx   <= '0;
              state <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A completed flit may replace the held one in the same cycle it is taken.
      if (flit_done && (!flit_valid || flit_ready)) begin
        flit_data  <= asm_q;
        flit_valid <= 1'b1;
      end else begin
        if (flit_valid && flit_ready) flit_valid <= 1'b0;
        if (flit_done) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_flit_rx.sv
// tb/tb_uart_flit_rx.sv - self-checking bench for uart_flit_rx with a byte-stream flit model
module tb_uart_flit_rx;
  localparam int CPB = 16;
  localparam int FW  = 32;
  localparam int NB  = FW / 8;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          uart_rx;
  logic          flit_ready;
  logic [FW-1:0] flit_data;
  logic          flit_valid;
  logic          frame_err;
  logic          overrun;
`ifdef UART_FLIT_RX_PARITY_EN
  logic          parity_err;
  int            pe_cnt = 0;
  int            both_cnt = 0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  int rise_cyc = 0;
  int stop_cyc = 0;
  int model_bad = 0;
  logic prev_valid = 1'b0;
  logic [FW-1:0] got[$];
  logic [FW-1:0] exp_q[$];
  logic [7:0]    part[$];

  uart_flit_rx #(.CLKS_PER_BIT(CPB), .FLIT_WIDTH(FW)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .uart_rx(uart_rx),
    .flit_data(flit_data),
    .flit_valid(flit_valid),
    .flit_ready(flit_ready),
    .frame_err(frame_err),
    .overrun(overrun)
`ifdef UART_FLIT_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so mid-cycle sampling sees what the next edge will see.
  always @(negedge clk) begin
    if (n_rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_FLIT_RX_PARITY_EN
      if (parity_err) pe_cnt++;
      if (parity_err && frame_err) both_cnt++;
`endif
      if (flit_valid) valid_cycles++;
      if (flit_valid && !prev_valid) rise_cyc = cyc;
      if (flit_valid && flit_ready) got.push_back(flit_data);
    end
    prev_valid = flit_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic good);
    logic [FW-1:0] f;
    if (!good) begin
      part.delete();
      model_bad++;
    end else begin
      part.push_back(b);
      if (part.size() == NB) begin
        f = '0;
        for (int i = 0; i < NB; i++) f = f | (FW'(part[i]) << (8 * i));
        exp_q.push_back(f);
        part.delete();
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_FLIT_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
    stop_cyc = cyc;
    drive_bit(stop_ok);
    drive_bit(1'b1);
    drive_bit(1'b1);
    model_byte(b, stop_ok && par_ok);
  endtask

  task automatic wait_flits(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 2000) begin
      tick();
      k++;
    end
    total++;
    if (got.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: flits seen=%0d required=%0d", name, got.size(), n);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    uart_rx = 1'b1;
    flit_ready = 1'b0;
    repeat (3) tick();
    total += 4;
    if (flit_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", flit_data); end
    if (flit_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", flit_valid); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_rst = 1'b1;
    repeat (CPB) tick();
    total++;
    if (flit_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", flit_valid); end
  endtask

  task automatic test_basic();
    int g0 = got.size();
    int v0 = valid_cycles;
    int f0 = fe_cnt;
    int o0 = ov_cnt;
    logic [7:0] bytes[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    flit_ready = 1'b1;
    foreach (bytes[i]) send_byte(bytes[i], 1'b1, 1'b1);
    wait_flits(g0 + 1, "basic");
    total += 6;
    if (got.size() > g0 && got[g0] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_data: got %h want deadbeef", got[g0]); end
    if (valid_cycles - v0 != 1) begin bad++; $display("FAIL basic_valid_len: got %0d want 1", valid_cycles - v0); end
    if (rise_cyc != stop_cyc + CPB / 2 + 4) begin bad++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - stop_cyc, CPB / 2 + 4); end
    if (fe_cnt != f0) begin bad++; $display("FAIL basic_frame_err: got %0d want 0", fe_cnt - f0); end
    if (ov_cnt != o0) begin bad++; $display("FAIL basic_overrun: got %0d want 0", ov_cnt - o0); end
    if (flit_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", flit_valid); end
  endtask

  task automatic test_backpressure();
    int g0 = got.size();
    int o0 = ov_cnt;
    logic [7:0] bytes[8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    flit_ready = 1'b0;
    foreach (bytes[i]) send_byte(bytes[i], 1'b1, 1'b1);
    total += 4;
    if (flit_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held: got %b want 1", flit_valid); end
    if (flit_data !== 32'h11223344) begin bad++; $display("FAIL bp_data_held: got %h want 11223344", flit_data); end
    if (ov_cnt - o0 != 1) begin bad++; $display("FAIL bp_overrun: got %0d want 1", ov_cnt - o0); end
    if (got.size() != g0) begin bad++; $display("FAIL bp_no_transfer: got %0d want 0", got.size() - g0); end
    flit_ready = 1'b1;
    tick();
    flit_ready = 1'b0;
    repeat (4) tick();
    total += 3;
    if (got.size() - g0 != 1) begin bad++; $display("FAIL bp_transfers: got %0d want 1", got.size() - g0); end
    if (got.size() > g0 && got[g0] !== 32'h11223344) begin bad++; $display("FAIL bp_xfer_data: got %h want 11223344", got[g0]); end
    if (flit_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop: got %b want 0", flit_valid); end
    exp_q.delete();
  endtask

  task automatic test_frame_err();
    int g0 = got.size();
    int f0 = fe_cnt;
    flit_ready = 1'b1;
    send_byte(8'hAA, 1'b1, 1'b1);
    send_byte(8'hBB, 1'b1, 1'b1);
    send_byte(8'hCC, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b1);
    wait_flits(g0 + 1, "frame");
    total += 3;
    if (fe_cnt - f0 != 1) begin bad++; $display("FAIL frame_pulses: got %0d want 1", fe_cnt - f0); end
    if (got.size() - g0 != 1) begin bad++; $display("FAIL frame_flits: got %0d want 1", got.size() - g0); end
    if (got.size() > g0 && got[g0] !== 32'h04030201) begin bad++; $display("FAIL frame_data: got %h want 04030201", got[g0]); end
    uart_rx = 1'b0;
    repeat (30 * CPB) tick();
    uart_rx = 1'b1;
    repeat (3 * CPB) tick();
    total++;
    if (fe_cnt - f0 != 2) begin bad++; $display("FAIL held_low_pulses: got %0d want 2", fe_cnt - f0); end
  endtask

  task automatic test_glitch();
    int g0 = got.size();
    int f0 = fe_cnt;
    flit_ready = 1'b1;
    send_byte(8'h10, 1'b1, 1'b1);
    send_byte(8'h20, 1'b1, 1'b1);
    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (2 * CPB) tick();
    send_byte(8'h30, 1'b1, 1'b1);
    send_byte(8'h40, 1'b1, 1'b1);
    wait_flits(g0 + 1, "glitch");
    total += 2;
    if (got.size() > g0 && got[g0] !== 32'h40302010) begin bad++; $display("FAIL glitch_data: got %h want 40302010", got[g0]); end
    if (fe_cnt != f0) begin bad++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_reset_mid();
    int g0;
    int f0 = fe_cnt;
    flit_ready = 1'b1;
    send_byte(8'h99, 1'b1, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    n_rst = 1'b0;
    #1;
    total += 4;
    if (flit_data !== '0) begin bad++; $display("FAIL midrst_data: got %h want 0", flit_data); end
    if (flit_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", flit_valid); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    part.delete();
    uart_rx = 1'b1;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (2 * CPB) tick();
    g0 = got.size();
    send_byte(8'h0D, 1'b1, 1'b1);
    send_byte(8'h0C, 1'b1, 1'b1);
    send_byte(8'h0B, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1);
    wait_flits(g0 + 1, "midrst");
    total += 2;
    if (got.size() > g0 && got[g0] !== 32'h0A0B0C0D) begin bad++; $display("FAIL midrst_flit: got %h want 0a0b0c0d", got[g0]); end
    if (fe_cnt != f0) begin bad++; $display("FAIL midrst_frame_err: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_random();
    int g0 = got.size();
    int e0;
    int f0 = fe_cnt;
    int o0 = ov_cnt;
    int b0 = model_bad;
    int n;
    logic done = 1'b0;
    exp_q.delete();
    part.delete();
    e0 = exp_q.size();
    fork
      begin
        for (int i = 0; i < 5 * NB; i++)
          send_byte(8'($urandom), ($urandom_range(0, 7) != 0), 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          flit_ready = 1'($urandom_range(0, 1));
          tick();
        end
        flit_ready = 1'b1;
      end
    join
    n = exp_q.size() - e0;
    wait_flits(g0 + n, "random");
    total += 3;
    if (got.size() - g0 != n) begin bad++; $display("FAIL rand_count: got %0d want %0d", got.size() - g0, n); end
    if (fe_cnt - f0 != model_bad - b0) begin bad++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt - f0, model_bad - b0); end
    if (ov_cnt != o0) begin bad++; $display("FAIL rand_overrun: got %0d want 0", ov_cnt - o0); end
    for (int i = 0; i < n && g0 + i < got.size(); i++) begin
      total++;
      if (got[g0 + i] !== exp_q[e0 + i]) begin
        bad++;
        $display("FAIL rand_flit%0d: got %h want %h", i, got[g0 + i], exp_q[e0 + i]);
      end
    end
  endtask

`ifdef UART_FLIT_RX_PARITY_EN
  task automatic test_parity();
    int g0 = got.size();
    int f0 = fe_cnt;
    int p0 = pe_cnt;
    int c0 = both_cnt;
    flit_ready = 1'b1;
    send_byte(8'h07, 1'b1, 1'b0);
    total += 3;
    if (pe_cnt - p0 != 1) begin bad++; $display("FAIL par_err_pulses: got %0d want 1", pe_cnt - p0); end
    if (fe_cnt - f0 != 1) begin bad++; $display("FAIL par_frame_pulses: got %0d want 1", fe_cnt - f0); end
    if (both_cnt - c0 != 1) begin bad++; $display("FAIL par_same_cycle: got %0d want 1", both_cnt - c0); end
    repeat (4) send_byte(8'h07, 1'b1, 1'b1);
    wait_flits(g0 + 1, "parity");
    total += 2;
    if (got.size() > g0 && got[g0] !== 32'h07070707) begin bad++; $display("FAIL par_flit: got %h want 07070707", got[g0]); end
    if (pe_cnt - p0 != 1) begin bad++; $display("FAIL par_good_no_err: got %0d want 1", pe_cnt - p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_random();
`ifdef UART_FLIT_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_flit_rx.md
Name: uart_flit_rx

Overview:
- Serial link receiver feeding one switch input buffer inside a tile; one instance per uart_rx pin.
- Deserializes 8N1 UART bytes and packs FLIT_WIDTH/8 bytes, LSB byte first, into one flit.
- Presents each flit to the switch ingress on a valid/ready handshake, and flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be ≥4 and even.
- FLIT_WIDTH, 32, flit width in bits; must be a multiple of 8 and ≥8.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- uart_rx  input  1  asynchronous serial line, idle high
- flit_data  output  FLIT_WIDTH  assembled flit
- flit_valid  output  1  flit_data holds a complete flit
- flit_ready  input  1  switch ingress accepts flit this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed flit dropped, holding register full

Behaviour:
- Clock and reset: one clock (clk); n_rst is asynchronous, active-low.
- Reset values:
  - flit_data=0, flit_valid=0, frame_err=0, overrun=0.
  - FSM=IDLE; bit counter, byte index, shift register and sync flops reset to idle values (sync flops to 1).
- Input synchronizer: uart_rx passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s, so there is 2 cycles of input latency.
- IDLE: on rx_s==0, load the cycle counter and go to START.
- START:
  - Wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - If 1: glitch. Return to IDLE; no error, byte index unchanged.
  - If 0: go to DATA with bit count 0.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles, at mid-bit.
  - Shift LSB first; after the 8th sample go to STOP.
- STOP: sample rx_s after CLKS_PER_BIT cycles.
  - Sampled 1, byte good:
    - Write the byte into the assembly register at lane [8*idx +: 8].
    - If idx<FLIT_WIDTH/8-1: increment idx.
    - Otherwise: flit complete, idx wraps to 0. Go to IDLE.
  - Sampled 0:
    - Pulse frame_err the following cycle.
    - Discard the byte and clear idx to 0, so the partial flit is abandoned.
    - Go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Flit completion (the cycle after the final stop sample):
  - If flit_valid==0, or flit_valid & flit_ready in that same cycle: load flit_data and set flit_valid=1 on the next edge.
  - Otherwise: drop the new flit, keep flit_data unchanged, and pulse overrun for one cycle.
- Handshake:
  - Transfer occurs on any cycle with flit_valid & flit_ready.
  - flit_valid falls the next cycle unless a new flit loads in that same cycle.
  - flit_data is stable while flit_valid=1 and no transfer occurs.
  - flit_ready while flit_valid=0 has no effect.
- Latency: flit_valid rises 2 (sync) + 1 (stop sample to completion) + 1 (load) cycles after the mid-stop-bit point of the last byte reaches the uart_rx pin.
- Reset mid-frame: everything returns to reset values immediately. Partial flits are lost and no error pulses are produced.
- The counters are $clog2-sized; the bit counter counts 0..CLKS_PER_BIT-1 and wraps.

Optional Feature:
- Macro: UART_FLIT_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state follows DATA and samples one extra bit.
  - The byte is good only if the XOR of the 8 data bits and the parity bit equals 0.
  - On mismatch: the frame_err pulse, idx clear and BREAK/IDLE handling match a bad stop bit. The stop bit is still sampled.
  - Port parity_err (output, 1): one-cycle pulse on mismatch, in the same cycle as frame_err. Resets to 0.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Test Plan:
1. Basic receive (CLKS_PER_BIT=16, FLIT_WIDTH=32): send bytes 0xEF,0xBE,0xAD,0xDE with flit_ready=1 -> flit_data=0xDEADBEEF, flit_valid high exactly 1 cycle, no error pulses.
2. Back-pressure and overrun: flit_ready=0; send 0x11223344 then 0x55667788 (byte order LSB first) -> flit_data stays 0x11223344, one overrun pulse at 2nd completion. Then raise flit_ready -> single transfer and flit_valid drops.
3. Framing error: send 0xAA,0xBB, then a byte with stop=0, then 0x01,0x02,0x03,0x04 -> one frame_err pulse; next flit=0x04030201 (partial discarded).
4. Start glitch: pull uart_rx low for 4 cycles, then send 4 valid bytes -> no frame_err, flit correct, idx unaffected.
5. Reset mid-byte: assert n_rst low during DATA of byte 2 -> all outputs 0. After release, 4 bytes 0x0D,0x0C,0x0B,0x0A -> flit 0x0A0B0C0D.
6. With UART_FLIT_RX_PARITY_EN: byte 0x07 with parity 0 -> parity_err and frame_err pulse together. Correct parity 1 -> accepted.
